// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port request/grant/done arbiter in front of the unified Memory.
// Round-robin by default; define MEM_ARB_CPU_PRIORITY_EN for fixed port-0 priority.
module mem_arbiter #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              done0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] endereco,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data
);

  localparam int               CNT_W    = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              port_q, port_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              win;

`ifndef MEM_ARB_CPU_PRIORITY_EN
  logic last_q, last_d;
`endif

  // win is the port id that takes the bus if a grant happens this cycle
  always_comb begin
`ifdef MEM_ARB_CPU_PRIORITY_EN
    win = ~req0;
`else
    if (req0 && req1) win = ~last_q;
    else              win = ~req0;
`endif
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    we_d      = we_q;
    port_d    = port_q;
    cnt_d     = cnt_q;
`ifndef MEM_ARB_CPU_PRIORITY_EN
    last_d    = last_q;
`endif
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          gnt0    = ~win;
          gnt1    = win;
          addr_d  = win ? addr1  : addr0;
          wdata_d = win ? wdata1 : wdata0;
          we_d    = win ? we1    : we0;
          port_d  = win;
          cnt_d   = '0;
`ifndef MEM_ARB_CPU_PRIORITY_EN
          last_d  = win;
`endif
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_write = we_q;
        mem_read  = ~we_q;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          if (!we_q) rdata_d = read_data;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        done0   = ~port_q;
        done1   = port_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      port_q  <= 1'b0;
      cnt_q   <= '0;
`ifndef MEM_ARB_CPU_PRIORITY_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      port_q  <= port_d;
      cnt_q   <= cnt_d;
`ifndef MEM_ARB_CPU_PRIORITY_EN
      last_q  <= last_d;
`endif
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign endereco   = addr_q;
  assign write_data = wdata_q;
  assign rdata      = rdata_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified Memory between two requesters: port 0 is the multicycle core's load/store/fetch path; port 1 is a loader/debug master that writes programs and reads back results.
- Sits between the requesters and the Memory instance, and drives mem_read, mem_write, endereco and write_data.
- Uses a request/grant/done handshake, round-robin arbitration and a configurable fixed memory access latency.

Parameters:
- ADDR_W, 64, address width (matches Memory endereco).
- DATA_W, 64, data width (matches Memory read_data/write_data).
- MEM_LATENCY, 1, cycles the memory strobe is held per access; legal range >= 1.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  port 0 request.
- we0  input  1  port 0 write enable (1 = write, 0 = read).
- addr0  input  ADDR_W  port 0 address.
- wdata0  input  DATA_W  port 0 write data.
- gnt0  output  1  port 0 grant pulse.
- done0  output  1  port 0 completion pulse.
- req1, we1, addr1, wdata1, gnt1, done1: same as port 0, for port 1.
- rdata  output  DATA_W  read data of the last completed read; shared by both ports.
- busy  output  1  high while in ACCESS or RESP.
- mem_read  output  1  Memory read strobe.
- mem_write  output  1  Memory write strobe.
- endereco  output  ADDR_W  Memory address.
- write_data  output  DATA_W  Memory write data.
- read_data  input  DATA_W  Memory read data.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). All state changes occur on the rising edge of clk.
- Reset values: state=IDLE; gnt0/1, done0/1, busy, mem_read, mem_write = 0; endereco, write_data, rdata = 0; latency counter = 0; last_gnt = 1 (so port 0 wins the first tie).
- IDLE:
  - If any req is high, select a winner, assert its gnt for this cycle only (combinational from state and req) and latch the winner's addr, we, wdata and port id on the edge. Next state is ACCESS.
  - If no req is high, stay in IDLE.
- Arbitration rules:
  - Only one req high: that port wins.
  - Both req high: the port not equal to last_gnt wins.
  - last_gnt is updated to the winner on the grant edge.
- ACCESS:
  - endereco and write_data are driven from the latched registers.
  - mem_write = latched we; mem_read = !latched we.
  - Held for exactly MEM_LATENCY cycles, counted by a counter of width clog2(MEM_LATENCY+1).
  - On the final ACCESS edge, rdata captures read_data for a read; rdata is unchanged for a write. Next state is RESP.
- RESP:
  - mem_read and mem_write = 0.
  - done of the latched port = 1 for exactly one cycle.
  - Next state is IDLE.
- Latency: grant cycle, then MEM_LATENCY ACCESS cycles, then the done cycle. With MEM_LATENCY=1, req seen in cycle 0 gives done in cycle 2. Throughput is one access per MEM_LATENCY+2 cycles.
- Requester rules:
  - Hold req, we, addr, wdata stable until gnt; they may change after gnt.
  - rdata is valid in the done cycle and stays stable until the next read completes.
- Boundary conditions:
  - req dropped after grant: ignored; the access completes and done still pulses.
  - req still high in the IDLE cycle after RESP: treated as a new request.
  - Both ports requesting continuously: strict alternation 0,1,0,1,... with no starvation.
  - gnt and done are never high in the same cycle; at most one gnt and one done are high in any cycle.
  - reset asserted in any state: next edge returns to IDLE with all outputs at reset values. No done is issued for the aborted access; last_gnt returns to 1.
  - mem_read and mem_write are never both 1.
- endereco and write_data hold their last value outside ACCESS. They are only meaningful while a strobe is high.

Optional Feature:
- Macro: MEM_ARB_CPU_PRIORITY_EN.
- Defined: fixed priority; port 0 always wins when both req are high, and last_gnt is unused. Port 1 is served only in an IDLE cycle where req0 is low.
- Undefined: the round-robin behaviour described above.

Test Plan:
- Reset then single read: req0=1, we0=0, addr0=0x10, memory holds 0xDEADBEEF_00000013 at 0x10 -> gnt0 in cycle 0, mem_read=1 with endereco=0x10 in cycle 1, done0=1 and rdata=0xDEADBEEF_00000013 in cycle 2.
- Port 1 write then port 0 read: req1 writes 0x1234 to addr 0x20, then port 0 reads 0x20 -> mem_write=1 with write_data=0x1234 for one cycle; port 0 read returns rdata=0x1234.
- Simultaneous requests held for 8 accesses -> grants 0,1,0,1,... with the first grant to port 0. With MEM_ARB_CPU_PRIORITY_EN defined, all grants go to port 0.
- MEM_LATENCY=3, read from port 1 -> mem_read high for exactly 3 cycles; done1 in cycle 4 after gnt1.
- Reset asserted in the second cycle of ACCESS (MEM_LATENCY=3) -> next cycle IDLE with mem_read=0, no done pulse, rdata=0, and the next tie is granted to port 0.
- req0 dropped the cycle after gnt0 -> access completes, done0 pulses once, then busy=0.
